// File: rtl/vdp18_scandoubler.sv
// Line doubler: captures the native 15 kHz raster at pixel rate into ping-pong line buffers and
// replays each stored line twice at the full 10.7 MHz enable rate.
module vdp18_scandoubler #(
    parameter int HSYNC_W = 26,
    parameter int BUF_AW  = 9
) (
    input  logic       clk_i,
    input  logic       reset_n_i,
    input  logic       clk_en_10m7_i,
    input  logic [3:0] col_i,
    input  logic       hsync_n_i,
    input  logic       vsync_n_i,
    input  logic       blank_n_i,
    output logic [3:0] col_o,
    output logic       hsync_n_o,
    output logic       vsync_n_o,
    output logic       blank_n_o
);

    localparam int                DEPTH  = 2 ** BUF_AW;
    localparam logic [BUF_AW-1:0] X_MAX  = '1;
    localparam logic [BUF_AW-1:0] HS_END = BUF_AW'(HSYNC_W);

    typedef enum logic [1:0] {REPLAY0, REPLAY1, OVERRUN} line_st_t;

    line_st_t          state_q, state_d;
    logic              in_ph_q, in_ph_d;
    logic              hs_prev_q, hs_prev_d;
    logic              bank_q, bank_d;
    logic [BUF_AW-1:0] wr_x_q, wr_x_d;
    logic [BUF_AW-1:0] line_len_q, line_len_d;
    logic [BUF_AW-1:0] rd_x_q, rd_x_d;

    logic              hs_fall;
    logic              we;
    logic              wbank;
    logic [BUF_AW-1:0] wa;

    logic [4:0]        rd_word_q;
    logic              s1_vld_q, s1_hsn_q, s1_vsn_q;

    logic [4:0]        mem0 [DEPTH];
    logic [4:0]        mem1 [DEPTH];

    always_comb begin
        state_d    = state_q;
        in_ph_d    = in_ph_q;
        hs_prev_d  = hs_prev_q;
        bank_d     = bank_q;
        wr_x_d     = wr_x_q;
        line_len_d = line_len_q;
        rd_x_d     = rd_x_q;
        hs_fall    = 1'b0;
        we         = 1'b0;
        wbank      = bank_q;
        wa         = wr_x_q;

        if (clk_en_10m7_i) begin
            in_ph_d = ~in_ph_q;
            if (!in_ph_q) begin
                hs_fall   = hs_prev_q && !hsync_n_i;
                hs_prev_d = hsync_n_i;
                we        = 1'b1;
                if (hs_fall) begin
                    // The sync pixel itself opens the new line in the freshly swapped bank.
                    line_len_d = wr_x_q;
                    bank_d     = ~bank_q;
                    wbank      = ~bank_q;
                    wa         = '0;
                    wr_x_d     = BUF_AW'(1);
                    in_ph_d    = 1'b1;
                end else if (wr_x_q != X_MAX) begin
                    wr_x_d = wr_x_q + 1'b1;
                end
            end

            if (hs_fall) begin
                rd_x_d  = '0;
                state_d = REPLAY0;
            end else if (line_len_q == '0) begin
                rd_x_d = '0;
            end else if (rd_x_q == line_len_q - 1'b1) begin
                if (state_q == REPLAY0) begin
                    rd_x_d  = '0;
                    state_d = REPLAY1;
                end else begin
                    state_d = OVERRUN;
                end
            end else begin
                rd_x_d = rd_x_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q    <= REPLAY0;
            in_ph_q    <= 1'b0;
            hs_prev_q  <= 1'b1;
            bank_q     <= 1'b0;
            wr_x_q     <= '0;
            line_len_q <= '0;
            rd_x_q     <= '0;
        end else begin
            state_q    <= state_d;
            in_ph_q    <= in_ph_d;
            hs_prev_q  <= hs_prev_d;
            bank_q     <= bank_d;
            wr_x_q     <= wr_x_d;
            line_len_q <= line_len_d;
            rd_x_q     <= rd_x_d;
        end
    end

    // Replay always reads the bank opposite the one being written.
    always_ff @(posedge clk_i) begin
        if (we) begin
            if (wbank) mem1[wa] <= {blank_n_i, col_i};
            else       mem0[wa] <= {blank_n_i, col_i};
        end
        if (clk_en_10m7_i) begin
            rd_word_q <= bank_q ? mem0[rd_x_q] : mem1[rd_x_q];
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            s1_vld_q  <= 1'b0;
            s1_hsn_q  <= 1'b1;
            s1_vsn_q  <= 1'b1;
            col_o     <= 4'd0;
            hsync_n_o <= 1'b1;
            vsync_n_o <= 1'b1;
            blank_n_o <= 1'b0;
        end else if (clk_en_10m7_i) begin
            s1_vld_q <= (line_len_q != '0) && (state_q != OVERRUN);
            s1_hsn_q <= !((line_len_q != '0) && (rd_x_q < HS_END));
            if ((rd_x_q == '0) && (state_q != OVERRUN)) begin
                s1_vsn_q <= vsync_n_i;
            end
            hsync_n_o <= s1_hsn_q;
            vsync_n_o <= s1_vsn_q;
            blank_n_o <= s1_vld_q & rd_word_q[4];
            col_o     <= (s1_vld_q & rd_word_q[4]) ? rd_word_q[3:0] : 4'd0;
        end
    end

endmodule
